// File: rtl/flash_rw_sequencer.sv
`timescale 1ns/1ps
// flash_rw_sequencer: erases a sector, programs one page with an incrementing pattern,
// reads it back and compares every byte, reporting pass/fail and a mismatch count.
module flash_rw_sequencer #(
  parameter logic [23:0] P_ADDR    = 24'h000000,
  parameter int unsigned P_NUM     = 256,
  parameter logic [7:0]  P_SEED    = 8'h00,
  parameter logic [31:0] P_TIMEOUT = 32'd50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [8:0]  o_err_cnt,
  output logic        o_timeout,
  output logic [1:0]  o_operation_type,
  output logic [23:0] o_operation_addr,
  output logic [8:0]  o_operation_num,
  output logic        o_operation_valid,
  input  logic        i_operation_ready,
  output logic [7:0]  o_write_data,
  output logic        o_write_sop,
  output logic        o_write_eop,
  output logic        o_write_valid,
  input  logic [7:0]  i_read_data,
  input  logic        i_read_sop,
  input  logic        i_read_eop,
  input  logic        i_read_valid
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(P_NUM);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(P_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      TMO_LAST = P_TIMEOUT - 32'd1;
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE_REQ, S_PROG_REQ, S_PROG_DATA, S_READ_REQ, S_READ_WAIT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        tmo_cnt_q, tmo_cnt_d;
  logic               op_valid_q, op_valid_d;
  logic [1:0]         op_type_q, op_type_d;
  logic [23:0]        op_addr_q, op_addr_d;
  logic [CNT_W-1:0]   op_num_q, op_num_d;
  logic               wr_valid_q, wr_valid_d;
  logic               wr_sop_q, wr_sop_d;
  logic               wr_eop_q, wr_eop_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [CNT_W-1:0]   tx_idx_q, tx_idx_d;
  logic [CNT_W-1:0]   rx_idx_q, rx_idx_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               len_err_q, len_err_d;
  logic               timeout_q, timeout_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               handshake;
  logic [7:0]         exp_byte;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      tmo_cnt_q  <= '0;
      op_valid_q <= 1'b0;
      op_type_q  <= '0;
      op_addr_q  <= '0;
      op_num_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_sop_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      wr_data_q  <= '0;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      err_cnt_q  <= '0;
      len_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      op_valid_q <= op_valid_d;
      op_type_q  <= op_type_d;
      op_addr_q  <= op_addr_d;
      op_num_q   <= op_num_d;
      wr_valid_q <= wr_valid_d;
      wr_sop_q   <= wr_sop_d;
      wr_eop_q   <= wr_eop_d;
      wr_data_q  <= wr_data_d;
      tx_idx_q   <= tx_idx_d;
      rx_idx_q   <= rx_idx_d;
      err_cnt_q  <= err_cnt_d;
      len_err_q  <= len_err_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Sequencer next-state; every output is precomputed here so it can be registered.
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    op_valid_d = op_valid_q;
    op_type_d  = op_type_q;
    op_addr_d  = op_addr_q;
    op_num_d   = op_num_q;
    wr_valid_d = wr_valid_q;
    wr_sop_d   = wr_sop_q;
    wr_eop_d   = wr_eop_q;
    wr_data_d  = wr_data_q;
    tx_idx_d   = tx_idx_q;
    rx_idx_d   = rx_idx_q;
    err_cnt_d  = err_cnt_q;
    len_err_d  = len_err_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    handshake  = op_valid_q & i_operation_ready;
    exp_byte   = P_SEED + rx_idx_q[7:0];

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_ERASE_REQ;
          op_valid_d = 1'b1;
          op_type_d  = OP_ERASE;
          op_addr_d  = P_ADDR;
          op_num_d   = '0;
          err_cnt_d  = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          tx_idx_d   = '0;
          rx_idx_d   = '0;
          len_err_d  = 1'b0;
        end
      end
      S_ERASE_REQ: begin
        if (handshake) begin
          op_valid_d = 1'b0;
          state_d    = S_PROG_REQ;
        end
      end
      S_PROG_REQ: begin
        // Valid is low for the cycle after the previous transfer, then re-raised.
        if (handshake) begin
          op_valid_d = 1'b0;
          state_d    = S_PROG_DATA;
          wr_valid_d = 1'b1;
          wr_sop_d   = 1'b1;
          wr_eop_d   = (NUM_C == 9'd1);
          wr_data_d  = P_SEED;
          tx_idx_d   = 9'd1;
        end else if (!op_valid_q) begin
          op_valid_d = 1'b1;
          op_type_d  = OP_PROG;
          op_num_d   = NUM_C;
        end
      end
      S_PROG_DATA: begin
        if (wr_eop_q) begin
          wr_valid_d = 1'b0;
          wr_sop_d   = 1'b0;
          wr_eop_d   = 1'b0;
          state_d    = S_READ_REQ;
        end else begin
          wr_data_d = P_SEED + tx_idx_q[7:0];
          wr_sop_d  = 1'b0;
          wr_eop_d  = (tx_idx_q == LAST_C);
          tx_idx_d  = tx_idx_q + 1'b1;
        end
      end
      S_READ_REQ: begin
        if (handshake) begin
          op_valid_d = 1'b0;
          state_d    = S_READ_WAIT;
        end else if (!op_valid_q) begin
          op_valid_d = 1'b1;
          op_type_d  = OP_READ;
          op_num_d   = NUM_C;
        end
      end
      S_READ_WAIT: begin
        // Bytes beyond the page are only flagged; a sop mid-stream is a framing error.
        if (i_read_valid) begin
          if (rx_idx_q < NUM_C) begin
            if ((i_read_data != exp_byte) && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
          end else begin
            len_err_d = 1'b1;
          end
          if (i_read_sop && (rx_idx_q != '0)) len_err_d = 1'b1;
          if (rx_idx_q != CNT_MAX) rx_idx_d = rx_idx_q + 1'b1;
          if (i_read_eop) begin
            if (rx_idx_q != LAST_C) len_err_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog: abort when a busy state makes no progress for P_TIMEOUT cycles.
    if ((state_q != S_IDLE) && (state_q != S_DONE) && (state_d == state_q) &&
        (tmo_cnt_q >= TMO_LAST)) begin
      state_d    = S_DONE;
      timeout_d  = 1'b1;
      op_valid_d = 1'b0;
      wr_valid_d = 1'b0;
      wr_sop_d   = 1'b0;
      wr_eop_d   = 1'b0;
    end

    tmo_cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? 32'd0 : tmo_cnt_q + 32'd1;

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      done_d = 1'b1;
      pass_d = (err_cnt_d == '0) & ~len_err_d & ~timeout_d;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_pass            = pass_q;
  assign o_err_cnt         = err_cnt_q;
  assign o_timeout         = timeout_q;
  assign o_operation_type  = op_type_q;
  assign o_operation_addr  = op_addr_q;
  assign o_operation_num   = op_num_q;
  assign o_operation_valid = op_valid_q;
  assign o_write_data      = wr_data_q;
  assign o_write_sop       = wr_sop_q;
  assign o_write_eop       = wr_eop_q;
  assign o_write_valid     = wr_valid_q;

endmodule

// File: tb/tb_flash_rw_sequencer.sv
`timescale 1ns/1ps
// Bench for flash_rw_sequencer: a flash driver model plus a queue scoreboard checked by
// an independent monitor; two instances cover a full page and a single-byte page.
module tb_flash_rw_sequencer;

  localparam int unsigned A_NUM  = 256;
  localparam logic [7:0]  A_SEED = 8'h00;
  localparam logic [23:0] A_ADDR = 24'h0ABC00;
  localparam logic [31:0] A_TMO  = 32'd5000;
  localparam int unsigned B_NUM  = 1;
  localparam logic [7:0]  B_SEED = 8'hA5;
  localparam logic [23:0] B_ADDR = 24'h000000;
  localparam logic [31:0] B_TMO  = 32'd100;

  typedef struct packed { logic [1:0] t; logic [23:0] a; logic [8:0] n; } op_t;
  typedef struct packed { logic pass; logic [8:0] err; logic tmo; } res_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0, ready = 1'b0;
  logic [7:0] rd_data = '0;
  logic rd_sop = 1'b0, rd_eop = 1'b0, rd_valid = 1'b0;

  logic a_busy, a_done, a_pass, a_tmo, a_op_valid, a_wr_sop, a_wr_eop, a_wr_valid;
  logic [8:0] a_err, a_op_num; logic [1:0] a_op_type; logic [23:0] a_op_addr; logic [7:0] a_wr_data;
  logic b_busy, b_done, b_pass, b_tmo, b_op_valid, b_wr_sop, b_wr_eop, b_wr_valid;
  logic [8:0] b_err, b_op_num; logic [1:0] b_op_type; logic [23:0] b_op_addr; logic [7:0] b_wr_data;

  logic m_busy, m_done, m_pass, m_tmo, m_op_valid, m_wr_sop, m_wr_eop, m_wr_valid;
  logic [8:0] m_err, m_op_num; logic [1:0] m_op_type; logic [23:0] m_op_addr; logic [7:0] m_wr_data;

  int n_checks = 0, n_fail = 0;
  op_t op_q[$]; logic [9:0] wr_q[$]; res_t res_q[$]; logic [7:0] rd_q[$];

  always #5 clk = ~clk;

  flash_rw_sequencer #(.P_ADDR(A_ADDR), .P_NUM(A_NUM), .P_SEED(A_SEED), .P_TIMEOUT(A_TMO)) u_dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_start(start & ~sel), .o_busy(a_busy), .o_done(a_done),
    .o_pass(a_pass), .o_err_cnt(a_err), .o_timeout(a_tmo), .o_operation_type(a_op_type),
    .o_operation_addr(a_op_addr), .o_operation_num(a_op_num), .o_operation_valid(a_op_valid),
    .i_operation_ready(ready), .o_write_data(a_wr_data), .o_write_sop(a_wr_sop),
    .o_write_eop(a_wr_eop), .o_write_valid(a_wr_valid), .i_read_data(rd_data),
    .i_read_sop(rd_sop), .i_read_eop(rd_eop), .i_read_valid(rd_valid));

  flash_rw_sequencer #(.P_ADDR(B_ADDR), .P_NUM(B_NUM), .P_SEED(B_SEED), .P_TIMEOUT(B_TMO)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_start(start & sel), .o_busy(b_busy), .o_done(b_done),
    .o_pass(b_pass), .o_err_cnt(b_err), .o_timeout(b_tmo), .o_operation_type(b_op_type),
    .o_operation_addr(b_op_addr), .o_operation_num(b_op_num), .o_operation_valid(b_op_valid),
    .i_operation_ready(ready), .o_write_data(b_wr_data), .o_write_sop(b_wr_sop),
    .o_write_eop(b_wr_eop), .o_write_valid(b_wr_valid), .i_read_data(rd_data),
    .i_read_sop(rd_sop), .i_read_eop(rd_eop), .i_read_valid(rd_valid));

  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;
  assign m_pass     = sel ? b_pass     : a_pass;
  assign m_tmo      = sel ? b_tmo      : a_tmo;
  assign m_err      = sel ? b_err      : a_err;
  assign m_op_valid = sel ? b_op_valid : a_op_valid;
  assign m_op_type  = sel ? b_op_type  : a_op_type;
  assign m_op_addr  = sel ? b_op_addr  : a_op_addr;
  assign m_op_num   = sel ? b_op_num   : a_op_num;
  assign m_wr_valid = sel ? b_wr_valid : a_wr_valid;
  assign m_wr_sop   = sel ? b_wr_sop   : a_wr_sop;
  assign m_wr_eop   = sel ? b_wr_eop   : a_wr_eop;
  assign m_wr_data  = sel ? b_wr_data  : a_wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  32'(m_busy), 32'd0);
    chk({tag, "_done"},  32'(m_done), 32'd0);
    chk({tag, "_pass"},  32'(m_pass), 32'd0);
    chk({tag, "_err"},   32'(m_err), 32'd0);
    chk({tag, "_tmo"},   32'(m_tmo), 32'd0);
    chk({tag, "_opv"},   32'(m_op_valid), 32'd0);
    chk({tag, "_opbus"}, 32'({m_op_type, m_op_num}), 32'd0);
    chk({tag, "_opaddr"}, 32'(m_op_addr), 32'd0);
    chk({tag, "_wr"},    32'({m_wr_valid, m_wr_sop, m_wr_eop, m_wr_data}), 32'd0);
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the queued expectations.
  initial begin : monitor
    logic prev_hs, prev_wr;
    op_t eo; logic [9:0] ew; res_t er;
    prev_hs = 1'b0; prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hs = 1'b0; prev_wr = 1'b0;
      end else begin
        if (prev_hs) chk("op_valid_drop", 32'(m_op_valid), 32'd0);
        if (prev_wr) chk("wr_contiguous", 32'(m_wr_valid), 32'd1);
        if (m_op_valid) begin
          if (op_q.size() == 0) chk("op_unexpected", 32'(m_op_valid), 32'd0);
          else begin
            eo = op_q[0];
            chk("op_type", 32'(m_op_type), 32'(eo.t));
            chk("op_addr", 32'(m_op_addr), 32'(eo.a));
            chk("op_num",  32'(m_op_num),  32'(eo.n));
            if (ready) void'(op_q.pop_front());
          end
        end
        if (m_wr_valid) begin
          if (wr_q.size() == 0) chk("wr_unexpected", 32'(m_wr_valid), 32'd0);
          else begin
            ew = wr_q.pop_front();
            chk("wr_beat", 32'({m_wr_sop, m_wr_eop, m_wr_data}), 32'(ew));
          end
        end
        if (m_done) begin
          if (res_q.size() == 0) chk("done_unexpected", 32'(m_done), 32'd0);
          else begin
            er = res_q.pop_front();
            chk("res_pass", 32'(m_pass), 32'(er.pass));
            chk("res_err",  32'(m_err),  32'(er.err));
            chk("res_tmo",  32'(m_tmo),  32'(er.tmo));
            chk("res_busy", 32'(m_busy), 32'd0);
          end
        end
        prev_hs = m_op_valid & ready;
        prev_wr = m_wr_valid & ~m_wr_eop;
      end
    end
  end

  function automatic int cur_num();  return sel ? int'(B_NUM) : int'(A_NUM); endfunction
  function automatic logic [7:0] cur_seed(); return sel ? B_SEED : A_SEED; endfunction
  function automatic logic [23:0] cur_addr(); return sel ? B_ADDR : A_ADDR; endfunction

  task automatic fill_good(input int len);
    rd_q.delete();
    for (int i = 0; i < len; i++) rd_q.push_back(8'(cur_seed() + 8'(i)));
  endtask

  // Reference: expected ops, program stream and verdict derived from the page rules.
  task automatic push_expect();
    int n, errs; logic [7:0] s; logic [9:0] w; res_t r;
    n = cur_num(); s = cur_seed(); errs = 0;
    op_q.push_back(op_t'{2'd2, cur_addr(), 9'd0});
    op_q.push_back(op_t'{2'd1, cur_addr(), 9'(n)});
    op_q.push_back(op_t'{2'd0, cur_addr(), 9'(n)});
    for (int k = 0; k < n; k++) begin
      w = {(k == 0), (k == n - 1), 8'(s + 8'(k))};
      wr_q.push_back(w);
    end
    for (int i = 0; i < rd_q.size(); i++)
      if (i < n && rd_q[i] != 8'(s + 8'(i))) errs++;
    if (errs > 511) errs = 511;
    r.err = 9'(errs); r.tmo = 1'b0;
    r.pass = (errs == 0) && (rd_q.size() == n);
    res_q.push_back(r);
  endtask

  task automatic flush();
    op_q.delete(); wr_q.delete(); res_q.delete();
  endtask

  task automatic start_seq();
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_busy",  32'(m_busy), 32'd1);
    chk("start_valid", 32'(m_op_valid), 32'd1);
    chk("start_type",  32'(m_op_type), 32'd2);
  endtask

  task automatic serve_req(input int stall, output bit ok);
    int n = 0;
    while (!m_op_valid && n < 3000) begin cyc(); n++; end
    ok = m_op_valid;
    if (!ok) begin chk("req_wait", 32'(m_op_valid), 32'd1); return; end
    repeat (stall) cyc();
    ready = 1'b1; cyc(); ready = 1'b0;
  endtask

  task automatic send_read(input int gap);
    for (int i = 0; i < rd_q.size(); i++) begin
      while (int'($urandom_range(99)) < gap) cyc();
      rd_valid = 1'b1; rd_data = rd_q[i];
      rd_sop = (i == 0); rd_eop = (i == rd_q.size() - 1);
      cyc();
      rd_valid = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = '0;
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (res_q.size() != 0 && n < 500) begin cyc(); n++; end
    chk("result_seen", 32'(res_q.size()), 32'd0);
  endtask

  task automatic resync();
    rst_n = 1'b0; flush(); repeat (2) cyc(); rst_n = 1'b1; cyc();
  endtask

  task automatic run_seq(input int stall, input int gap);
    bit ok;
    push_expect();
    start_seq();
    for (int r = 0; r < 3; r++) begin
      serve_req(stall, ok);
      if (!ok) begin resync(); return; end
    end
    send_read(gap);
    wait_result();
    if (res_q.size() != 0) resync();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int len, nc, p, n;
    bit ok;
    #3; sel = 1'b0; check_zero("rst_a");
    sel = 1'b1; #1; check_zero("rst_b");
    sel = 1'b0;
    cyc(); rst_n = 1'b1; cyc();

    fill_good(A_NUM); run_seq(0, 0);                       // perfect read-back
    fill_good(A_NUM); rd_q[5] ^= 8'h01; rd_q[200] ^= 8'h01; // two corrupted bytes, back-to-back start
    run_seq(0, 0);
    fill_good(A_NUM); run_seq(1000, 0);                    // driver busy for 1000 cycles per request
    fill_good(A_NUM - 1); run_seq(0, 0);                   // short read stream
    fill_good(A_NUM + 1); rd_q[A_NUM] = 8'h55; run_seq(0, 10); // over-long read stream

    for (int r = 0; r < 4; r++) begin
      len = int'(A_NUM);
      if ($urandom_range(3) == 0) len = 250 + int'($urandom_range(10));
      fill_good(len);
      nc = int'($urandom_range(3));
      for (int c = 0; c < nc; c++) begin
        p = int'($urandom_range(len - 1));
        rd_q[p] = rd_q[p] ^ 8'(1 + $urandom_range(254));
      end
      run_seq(int'($urandom_range(4)), 30);
    end

    sel = 1'b1; cyc();
    fill_good(B_NUM); run_seq(0, 0);                       // single-byte page
    rd_q.delete(); rd_q.push_back(8'hA4); run_seq(2, 0);
    fill_good(2); run_seq(0, 0);

    // Erase request never accepted: watchdog abort after exactly B_TMO cycles of valid
    op_q.push_back(op_t'{2'd2, B_ADDR, 9'd0});
    res_q.push_back(res_t'{1'b0, 9'd0, 1'b1});
    start_seq();
    n = 1;
    while (m_op_valid && n < 1000) begin cyc(); if (m_op_valid) n++; end
    chk("tmo_valid_cycles", 32'(n), B_TMO);
    chk("tmo_done_edge", 32'(m_done), 32'd1);
    wait_result(); flush(); cyc();

    // Asynchronous reset in the middle of the program stream
    sel = 1'b0; cyc();
    fill_good(A_NUM); push_expect(); start_seq();
    serve_req(0, ok); if (ok) serve_req(0, ok);
    n = 0;
    while (!m_wr_valid && n < 50) begin cyc(); n++; end
    chk("midrst_streaming", 32'(m_wr_valid), 32'd1);
    repeat (10) cyc();
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    flush(); repeat (3) cyc(); rst_n = 1'b1;
    repeat (30) cyc();
    chk("midrst_idle", 32'({m_busy, m_done, m_op_valid}), 32'd0);

    fill_good(A_NUM); run_seq(1, 20);                      // recovery after reset
    repeat (5) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
